// File: rtl/cmd_fetch_decode.sv
// Command fetch/decode/validate stage: fetches one command word, checks it against
// per-slot degree state and issues it downstream. Define CMD_FETCH_DECODE_ERR_CNT_EN to add err_cnt.
module cmd_fetch_decode #(
    parameter int OPC_W   = 8,
    parameter int SLOT_W  = 3,
    parameter int ARG2_W  = 5,
    parameter int DEG_W   = 4,
    parameter int MAX_DEG = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               cont,
    input  logic [OPC_W+SLOT_W+ARG2_W-1:0]     cmd_in,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [(2**SLOT_W)*DEG_W-1:0]       slot_deg,
    output logic                               dec_valid,
    input  logic                               dec_ready,
    output logic [OPC_W-1:0]                   instr,
    output logic [SLOT_W-1:0]                  arg1,
    output logic [ARG2_W-1:0]                  arg2,
    output logic [2:0]                         error,
    output logic                               done,
`ifdef CMD_FETCH_DECODE_ERR_CNT_EN
    output logic [7:0]                         err_cnt,
`endif
    output logic [1:0]                         state_dbg
);
    localparam int CMD_W = OPC_W + SLOT_W + ARG2_W;

    localparam logic [OPC_W-1:0] OPC_SET_DEG    = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_EVAL       = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_WRITE_COEF = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_CLEAR      = OPC_W'(3);

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_OPC   = 3'd1;
    localparam logic [2:0] ERR_DEG   = 3'd2;
    localparam logic [2:0] ERR_EMPTY = 3'd3;
    localparam logic [2:0] ERR_COEF  = 3'd4;

    localparam logic [31:0] MAX_DEG_U = MAX_DEG;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DECODE = 2'd2, ISSUE = 2'd3} state_t;

    state_t             state;
    logic [CMD_W-1:0]   cmd_reg;

    logic [OPC_W-1:0]   c_opc;
    logic [SLOT_W-1:0]  c_arg1;
    logic [ARG2_W-1:0]  c_arg2;
    logic [DEG_W-1:0]   deg_sel;
    logic [31:0]        a2_u;
    logic [31:0]        deg_u;
    logic               slot_empty;
    logic [OPC_W-1:0]   d_instr;
    logic [SLOT_W-1:0]  d_arg1;
    logic [ARG2_W-1:0]  d_arg2;
    logic [2:0]         d_err;

    assign c_opc     = cmd_reg[CMD_W-1 -: OPC_W];
    assign c_arg1    = cmd_reg[ARG2_W +: SLOT_W];
    assign c_arg2    = cmd_reg[ARG2_W-1:0];
    assign deg_sel   = slot_deg[int'(c_arg1)*DEG_W +: DEG_W];
    // Zero-extending both operands to 32 bits covers any ARG2_W/DEG_W mix.
    assign a2_u       = 32'(c_arg2);
    assign deg_u      = 32'(deg_sel);
    assign slot_empty = (deg_sel == {DEG_W{1'b1}});
    assign state_dbg  = state;

    always_comb begin
        d_instr = c_opc;
        d_arg1  = c_arg1;
        d_arg2  = c_arg2;
        d_err   = ERR_OK;
        case (c_opc)
            OPC_SET_DEG: begin
                if (a2_u > MAX_DEG_U) d_err = ERR_DEG;
            end
            OPC_EVAL: begin
                d_arg2 = '0;
                if (slot_empty) d_err = ERR_EMPTY;
            end
            OPC_WRITE_COEF: begin
                if (slot_empty)          d_err = ERR_EMPTY;
                else if (a2_u > deg_u)   d_err = ERR_COEF;
            end
            OPC_CLEAR: begin
                d_arg1 = '0;
                d_arg2 = '0;
            end
            default: d_err = ERR_OPC;
        endcase
    end

    // Both handshakes: a transfer happens on a clk edge where valid and ready are both 1;
    // ready/valid outputs are registered, so neither cmd_valid nor dec_ready reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_reg   <= '0;
            cmd_ready <= 1'b0;
            dec_valid <= 1'b0;
            done      <= 1'b0;
            instr     <= '0;
            arg1      <= '0;
            arg2      <= '0;
            error     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        cmd_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (cmd_valid) begin
                        cmd_reg   <= cmd_in;
                        cmd_ready <= 1'b0;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    // A rejected command leaves the last good decode visible; only error moves.
                    error <= d_err;
                    if (d_err == ERR_OK) begin
                        instr <= d_instr;
                        arg1  <= d_arg1;
                        arg2  <= d_arg2;
                    end
                    dec_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        done      <= 1'b1;
                        if (cont) begin
                            state     <= FETCH;
                            cmd_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMD_FETCH_DECODE_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (state == ISSUE && dec_ready && error != ERR_OK && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
